// File: rtl/actuator_timer_bank.sv
// Memory-mapped bank of NCH actuator countdown timers with one-shot/periodic
// modes, sticky W1C completion flags and a maskable interrupt.
module actuator_timer_bank #(
  parameter int          NCH       = 2,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [NCH-1:0]   active,
  output logic             done_any,
  output logic             irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic             hit;
  logic [9:0]       word;
  logic             status_wr;
  logic             ien_wr;
  logic [NCH-1:0]   done_reg, done_next, done_set;
  logic [NCH-1:0]   ien_reg, ien_next;
  logic [CNT_W-1:0] dur_q [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic             unused_bits;

  // Word index within the 4 KiB window; channel registers live below 0x100.
  assign hit         = (addr[31:12] == BASE_ADDR[31:12]);
  assign word        = addr[11:2];
  assign status_wr   = we && hit && (word == 10'h040);
  assign ien_wr      = we && hit && (word == 10'h041);
  assign unused_bits = ^{addr[1:0], wdata};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic             sel, ctrl_wr, dur_wr, start, stop, fin;
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next, dur_reg, dur_next;
      logic             periodic_reg, periodic_next;

      assign sel     = hit && (word[9:6] == 4'd0) && (word[5:2] == 4'(gi));
      assign ctrl_wr = we && sel && (word[1:0] == 2'd0);
      assign dur_wr  = we && sel && (word[1:0] == 2'd1);
      assign start   = ctrl_wr && wdata[0];
      assign stop    = ctrl_wr && wdata[1];

      always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        fin           = 1'b0;
        dur_next      = dur_wr ? wdata[CNT_W-1:0] : dur_reg;
        periodic_next = ctrl_wr ? wdata[2] : periodic_reg;
        case (state_reg)
          IDLE: begin
            if (start && !stop) begin
              if (dur_reg != '0) begin
                state_next = RUN;
                cnt_next   = dur_reg;
              end else begin
                fin = 1'b1;
              end
            end
          end
          RUN: begin
            // Bus commands take priority over a completion on the same edge.
            if (stop) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (start) begin
              cnt_next = dur_reg;
            end else if (cnt_reg < CNT_W'(2)) begin
              fin = 1'b1;
              if (periodic_reg && (dur_reg != '0)) begin
                cnt_next = dur_reg;
              end else begin
                state_next = IDLE;
                cnt_next   = '0;
              end
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          dur_reg      <= '0;
          periodic_reg <= 1'b0;
        end else begin
          state_reg    <= state_next;
          cnt_reg      <= cnt_next;
          dur_reg      <= dur_next;
          periodic_reg <= periodic_next;
        end
      end

      assign active[gi]   = (state_reg == RUN);
      assign done_set[gi] = fin;
      assign dur_q[gi]    = dur_reg;
      assign cnt_q[gi]    = cnt_reg;
    end
  endgenerate

  // Hardware completion wins over a software clear on the same edge.
  always_comb begin
    done_next = done_reg;
    if (status_wr) begin
      done_next = done_reg & ~wdata[NCH-1:0];
    end
    done_next = done_next | done_set;
    ien_next  = ien_wr ? wdata[NCH-1:0] : ien_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_reg <= '0;
      ien_reg  <= '0;
    end else begin
      done_reg <= done_next;
      ien_reg  <= ien_next;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      if (word == 10'h040) begin
        rdata[NCH-1:0] = done_reg;
      end else if (word == 10'h041) begin
        rdata[NCH-1:0] = ien_reg;
      end else if (word[9:6] == 4'd0) begin
        for (int i = 0; i < NCH; i++) begin
          if (word[5:2] == 4'(i)) begin
            if (word[1:0] == 2'd1) rdata[CNT_W-1:0] = dur_q[i];
            else if (word[1:0] == 2'd2) rdata[CNT_W-1:0] = cnt_q[i];
          end
        end
      end
    end
  end

  assign done_any = |done_reg;
  assign irq      = |(done_reg & ien_reg);

endmodule

// File: doc/actuator_timer_bank.md
ACTUATOR_TIMER_BANK -- requirements
Module: actuator_timer_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of actuator channels (legal 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of duration and countdown registers (legal 4..32).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_2000, MMIO base; decode hit when addr[31:12]==BASE_ADDR[31:12].
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 we  input  1  bus write strobe (MemWrite).
REQ-007 addr  input  32  bus byte address; addr[1:0] ignored.
REQ-008 wdata  input  32  bus write data.
REQ-009 rdata  output  32  bus read data, combinational from addr.
REQ-010 active  output  NCH  per-channel actuator drive (bit0 irrigation, bit1 ventilation in default build).
REQ-011 done_any  output  1  OR of all sticky DONE bits.
REQ-012 irq  output  1  OR of (DONE & IRQ_EN).

Function
REQ-013 Register map (offset from base) SHALL be: CH i CTRL 0x10*i (WO), DUR 0x10*i+4 (RW, CNT_W bits), CNT 0x10*i+8 (RO); STATUS 0x100 (DONE[NCH-1:0], W1C); IRQ_EN 0x104 (RW, NCH bits).
REQ-014 CTRL write bits SHALL be: bit0 START, bit1 STOP, bit2 PERIODIC (latched on every CTRL write); START/STOP are self-clearing strobes, read back 0.
REQ-015 Reads of unmapped offsets, CTRL, or channels >= NCH SHALL return 0; writes to them SHALL be ignored; no effect when decode misses.
REQ-016 Register read fields narrower than 32 bits SHALL be zero-extended; writes SHALL take the low bits of wdata.
REQ-017 Each channel SHALL run a 2-state FSM: IDLE, RUN.
REQ-018 IDLE + START with DUR!=0 -> RUN, CNT<=DUR on the same edge the write is sampled.
REQ-019 IDLE + START with DUR==0 -> stay IDLE, set DONE[i] on that edge, active[i] never asserts.
REQ-020 In RUN, CNT SHALL decrement by 1 each cycle and active[i] SHALL be 1; active[i]==(state==RUN) with no extra latency.
REQ-021 RUN with CNT==1: set DONE[i]; if PERIODIC reload CNT<=DUR and stay RUN (DUR==0 at reload -> IDLE); else -> IDLE with CNT=0.
REQ-022 Consequence: non-periodic START sampled at edge t gives active[i]=1 for exactly DUR cycles, DONE[i] visible after edge t+DUR.
REQ-023 RUN + STOP -> IDLE, CNT<=0, DONE not set; STOP and START in one write: STOP wins.
REQ-024 RUN + START (restart) SHALL reload CNT<=DUR and stay RUN without setting DONE.
REQ-025 DUR writes during RUN SHALL not alter the current CNT; they take effect at next START or periodic reload.
REQ-026 STATUS write SHALL clear DONE bits where wdata bit is 1; if hardware sets a DONE bit on the same edge, set wins.
REQ-027 Channels SHALL operate independently; simultaneous completion on several channels SHALL set all corresponding DONE bits on one edge.
REQ-028 CNT SHALL never wrap below 0 (no underflow in any path).

Reset
REQ-029 While reset==0 at a rising edge: all channels IDLE, CNT=0, DUR=0, PERIODIC=0, DONE=0, IRQ_EN=0; hence active=0, done_any=0, irq=0, rdata reflects zeroed registers.
REQ-030 Reset asserted mid-RUN SHALL drop active on that edge without setting DONE; bus writes in the same cycle are ignored.

Verification
REQ-031 NCH=2, CNT_W=16: DUR0=5, START ch0 -> active[0]=1 for exactly 5 cycles, then DONE=2'b01, done_any=1, irq=0; IRQ_EN=1 -> irq=1; write STATUS=1 -> all 0.
REQ-032 DUR1=3, CTRL1=START|PERIODIC -> active[1] held continuously, DONE[1] set every 3 cycles; STOP after 7 cycles -> active[1]=0, CNT1 reads 0.
REQ-033 DUR0=0, START -> active[0] never 1, DONE[0]=1 on next edge.
REQ-034 DUR0=4 and DUR1=4, both started same cycle -> both done on same edge, STATUS reads 2'b11; W1C of bit0 on completing edge of a rerun -> bit0 remains 1 (set wins).
REQ-035 DUR0=10, START, reset low at cycle 3 -> active=0, CNT0=0, DUR0=0, DONE=0 next edge; read of 0x10C and 0x200 returns 0.
REQ-036 DUR0=6, START, write DUR0=2 at cycle 2, START|STOP at cycle 4 -> first run not shortened until STOP wins at cycle 4, no DONE; next START runs 2 cycles.
